// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the logic processing element on a mesh
// NoC router local port.
//   - flit geometry for the default 64-bit payload / 4-bit address build
//   - flit_t packed flit layout {valid, head, dest, vc, data}
//   - logic_op_e operation select encoding
//   - pe_state_e top-level FSM states
package noc_pkg;

  localparam int NOC_DATA_W     = 64;
  localparam int NOC_DEST_W     = 4;
  localparam int NOC_FLIT_W     = NOC_DATA_W + NOC_DEST_W + 3;
  localparam int FLIT_VALID_POS = NOC_FLIT_W - 1;
  localparam int FLIT_HEAD_POS  = NOC_FLIT_W - 2;
  localparam int FLIT_VC_POS    = NOC_DATA_W;

  typedef struct packed {
    logic                  valid;
    logic                  head;
    logic [NOC_DEST_W-1:0] dest;
    logic                  vc;
    logic [NOC_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } logic_op_e;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_SEND    = 1'b1
  } pe_state_e;

endpackage

// File: rtl/noc_logic_pe_if.sv
// noc_logic_pe_if: local-port bundle between a router and the logic PE.
//   in_flit/in_ready   : operand flits into the PE (ready-only handshake)
//   op_sel             : operation select, sampled when an operand pair completes
//   out_flit/out_valid/out_ready : result flits out of the PE (valid/ready)
//   busy               : PE is emitting results
// Modports: slave = PE side, master = router/driver side.
interface noc_logic_pe_if #(
  parameter int FLIT_W = noc_pkg::NOC_FLIT_W
) ();
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic [1:0]        op_sel;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  in_flit, op_sel, out_ready,
    output in_ready, out_flit, out_valid, busy
  );

  modport master (
    output in_flit, op_sel, out_ready,
    input  in_ready, out_flit, out_valid, busy
  );
endinterface

// File: rtl/noc_flit_fanout.sv
// noc_flit_fanout: emits one result flit per entry of DEST_LIST/VC_LIST.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : load the first flit of a new result (start_data_i)
//   result_i       : stored result used for the following flits
//   out_ready_i    : downstream accepts out_flit_o
//   out_flit_o     : registered result flit
//   out_valid_o    : registered valid
//   done_o         : last flit of the list is being handed off this cycle
module noc_flit_fanout #(
  parameter int                         DATA_W    = 64,
  parameter int                         DEST_W    = 4,
  parameter int                         NUM_DEST  = 2,
  parameter logic [NUM_DEST*DEST_W-1:0] DEST_LIST = {4'b0101, 4'b0101},
  parameter logic [NUM_DEST-1:0]        VC_LIST   = 2'b00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [DATA_W-1:0]        start_data_i,
  input  logic [DATA_W-1:0]        result_i,
  input  logic                     out_ready_i,
  output logic [DATA_W+DEST_W+2:0] out_flit_o,
  output logic                     out_valid_o,
  output logic                     done_o
);

  localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  logic [IDX_W-1:0]         idx_q, idx_d, idx_nxt_s;
  logic [DATA_W+DEST_W+2:0] out_flit_q, out_flit_d;
  logic                     out_valid_q, out_valid_d;
  logic                     fire_s, last_s;

  // Shifts instead of variable part-selects keep the table lookup width-clean
  // for any NUM_DEST.
  function automatic logic [DATA_W+DEST_W+2:0] make_flit_f(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] data
  );
    logic [DEST_W-1:0] dest;
    logic              vc;
    dest = DEST_W'(DEST_LIST >> (int'(idx) * DEST_W));
    vc   = 1'(VC_LIST >> idx);
    make_flit_f = {1'b1, 1'b1, dest, vc, data};
  endfunction

  assign fire_s    = out_valid_q & out_ready_i;
  assign last_s    = (idx_q == IDX_W'(NUM_DEST - 1));
  assign idx_nxt_s = idx_q + IDX_W'(1);
  assign done_o    = fire_s & last_s;

  // Next-state: load on start, advance the table on each handshake.
  always_comb begin
    idx_d       = idx_q;
    out_flit_d  = out_flit_q;
    out_valid_d = out_valid_q;
    if (start_i) begin
      idx_d       = {IDX_W{1'b0}};
      out_flit_d  = make_flit_f({IDX_W{1'b0}}, start_data_i);
      out_valid_d = 1'b1;
    end else if (fire_s) begin
      if (last_s) begin
        idx_d       = {IDX_W{1'b0}};
        out_valid_d = 1'b0;
      end else begin
        idx_d       = idx_nxt_s;
        out_flit_d  = make_flit_f(idx_nxt_s, result_i);
        out_valid_d = 1'b1;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= {IDX_W{1'b0}};
      out_flit_q  <= {(DATA_W+DEST_W+3){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_flit_o  = out_flit_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/noc_logic_pe.sv
// noc_logic_pe: bitwise-logic processing element on a NoC local port.
// Collects operand A (vc=0) and operand B (vc=1) head flits, computes
// AND/OR/XOR/NAND per op_sel when the pair completes, then fans the result
// out as NUM_DEST flits via noc_flit_fanout.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : noc_logic_pe_if.slave (in_flit/in_ready, op_sel,
//              out_flit/out_valid/out_ready, busy)
// Build option: define NOC_LOGIC_PE_CONST_A_EN to fix operand A to CONST_A;
// vc=0 flits are then ignored and every accepted vc=1 flit completes a pair.
module noc_logic_pe
  import noc_pkg::*;
#(
  parameter int                         DATA_W    = NOC_DATA_W,
  parameter int                         DEST_W    = NOC_DEST_W,
  parameter int                         NUM_DEST  = 2,
  parameter logic [NUM_DEST*DEST_W-1:0] DEST_LIST = {4'b0101, 4'b0101},
  parameter logic [NUM_DEST-1:0]        VC_LIST   = 2'b00,
  parameter logic [DATA_W-1:0]          CONST_A   = 64'd6
) (
  input logic           clk,
  input logic           rst,
  noc_logic_pe_if.slave bus
);

  localparam int FLIT_W    = DATA_W + DEST_W + 3;
  localparam int VALID_POS = FLIT_W - 1;
  localparam int HEAD_POS  = FLIT_W - 2;
  localparam int VC_POS    = DATA_W;

  pe_state_e         state_q, state_d;
  logic              flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic              in_ready_s, accept_s, start_s, done_s, flit_vc_s;
  logic [DATA_W-1:0] flit_data_s;
  logic [FLIT_W-1:0] out_flit_s;
  logic              out_valid_s;
  logic              unused_dest_s;

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic_op_e         op
  );
    case (op)
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NAND: alu_f = ~(a & b);
      default: alu_f = a & b;
    endcase
  endfunction

  assign in_ready_s    = (state_q == ST_COLLECT);
  assign flit_vc_s     = bus.in_flit[VC_POS];
  assign flit_data_s   = bus.in_flit[DATA_W-1:0];
  // The incoming destination is this PE's own address; nothing to decode.
  assign unused_dest_s = ^bus.in_flit[VC_POS+DEST_W:VC_POS+1];

`ifdef NOC_LOGIC_PE_CONST_A_EN
  assign accept_s = bus.in_flit[VALID_POS] & bus.in_flit[HEAD_POS] & in_ready_s & flit_vc_s;
`else
  assign accept_s = bus.in_flit[VALID_POS] & bus.in_flit[HEAD_POS] & in_ready_s;
`endif

  // FSM next-state: operand capture, pair completion, return after fan-out.
  always_comb begin
    state_d  = state_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    start_s  = 1'b0;
`ifdef NOC_LOGIC_PE_CONST_A_EN
    flag_a_d = 1'b1;
    op_a_d   = CONST_A;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          // A repeat flit to a filled slot just overwrites the operand.
          if (flit_vc_s) begin
            op_b_d   = flit_data_s;
            flag_b_d = 1'b1;
          end else begin
            op_a_d   = flit_data_s;
            flag_a_d = 1'b1;
          end
          // Complete on the accepting edge using the freshly captured operand.
          if (flag_a_d && flag_b_d) begin
            result_d = alu_f(op_a_d, op_b_d, logic_op_e'(bus.op_sel));
            start_s  = 1'b1;
            state_d  = ST_SEND;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_SEND: begin
        if (done_s) begin
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
          state_d  = ST_COLLECT;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_COLLECT;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      op_a_q   <= {DATA_W{1'b0}};
      op_b_q   <= {DATA_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

  noc_flit_fanout #(
    .DATA_W   (DATA_W),
    .DEST_W   (DEST_W),
    .NUM_DEST (NUM_DEST),
    .DEST_LIST(DEST_LIST),
    .VC_LIST  (VC_LIST)
  ) u_fanout (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_s),
    .start_data_i(result_d),
    .result_i    (result_q),
    .out_ready_i (bus.out_ready),
    .out_flit_o  (out_flit_s),
    .out_valid_o (out_valid_s),
    .done_o      (done_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = (state_q == ST_SEND);
  assign bus.out_flit  = out_flit_s;
  assign bus.out_valid = out_valid_s;

endmodule

// File: tb/tb_noc_logic_pe.sv
module tb_noc_logic_pe;
  import noc_pkg::*;

  localparam int          NUM_DEST  = 2;
  localparam logic [7:0]  DEST_LIST = {4'b0101, 4'b0101};
  localparam logic [1:0]  VC_LIST   = 2'b00;
  localparam logic [63:0] CONST_A   = 64'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  noc_logic_pe_if bus ();

  noc_logic_pe #(
    .DATA_W(64), .DEST_W(4), .NUM_DEST(NUM_DEST),
    .DEST_LIST(DEST_LIST), .VC_LIST(VC_LIST), .CONST_A(CONST_A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: pending result flits and collected operands.
  flit_t       exp_q[$];
  logic [63:0] m_a, m_b;
  bit          m_has_a, m_has_b;
  flit_t       cur_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] model_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic push_results(input logic [63:0] r);
    flit_t f;
    for (int k = 0; k < NUM_DEST; k++) begin
      f.valid = 1'b1;
      f.head  = 1'b1;
      f.dest  = DEST_LIST[k*4 +: 4];
      f.vc    = VC_LIST[k];
      f.data  = r;
      exp_q.push_back(f);
    end
  endtask

  // Compare DUT outputs against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_has_a = 1'b0;
      m_has_b = 1'b0;
    end else begin
      cur_in = bus.in_flit;
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("in_ready", bus.in_ready, exp_q.size() == 0);
      check("busy", bus.busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_flit", bus.out_flit, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end else if (cur_in.valid && cur_in.head) begin
`ifdef NOC_LOGIC_PE_CONST_A_EN
        if (cur_in.vc) push_results(model_op(CONST_A, cur_in.data, bus.op_sel));
`else
        if (cur_in.vc) begin
          m_b = cur_in.data; m_has_b = 1'b1;
        end else begin
          m_a = cur_in.data; m_has_a = 1'b1;
        end
        if (m_has_a && m_has_b) begin
          push_results(model_op(m_a, m_b, bus.op_sel));
          m_has_a = 1'b0;
          m_has_b = 1'b0;
        end
`endif
      end
    end
  end

  // Present one flit for exactly one clock edge (call at posedge+1).
  task automatic send(input bit vc, input logic [63:0] data, input bit valid = 1'b1, input bit head = 1'b1);
    flit_t f;
    f.valid = valid; f.head = head; f.dest = 4'b0101; f.vc = vc; f.data = data;
    bus.in_flit = f;
    @(posedge clk); #1;
    bus.in_flit = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n < 200, 1'b1);
  endtask

  function automatic logic [70:0] lit_flit(input logic [63:0] d);
    return {1'b1, 1'b1, 4'b0101, 1'b0, d};
  endfunction

  initial begin
    int cnt;
    bus.in_flit   = '0;
    bus.op_sel    = 2'b00;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_flit", bus.out_flit, 71'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // AND: A=6 then B=0xF -> two flits of 0x6, first one cycle after B.
    bus.op_sel = 2'b00;
    send(1'b0, 64'h6);
    send(1'b1, 64'hF);
    @(negedge clk);
    check("t1_valid0", bus.out_valid, 1'b1);
    check("t1_flit0", bus.out_flit, lit_flit(64'h6));
    @(negedge clk);
    check("t1_valid1", bus.out_valid, 1'b1);
    check("t1_flit1", bus.out_flit, lit_flit(64'h6));
    @(negedge clk);
    check("t1_done_valid", bus.out_valid, 1'b0);
    check("t1_done_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

`ifndef NOC_LOGIC_PE_CONST_A_EN
    // XOR with B arriving first.
    bus.op_sel = 2'b10;
    send(1'b1, 64'h0F);
    send(1'b0, 64'hFF);
    @(negedge clk);
    check("t2_xor", bus.out_flit, lit_flit(64'hF0));
    @(posedge clk); #1;
    wait_idle("t2_idle");

    // Backpressure: held 5 cycles with a competing flit presented.
    bus.out_ready = 1'b0;
    bus.op_sel    = 2'b01;
    send(1'b0, 64'h30);
    send(1'b1, 64'h05);
    bus.in_flit = {1'b1, 1'b1, 4'b0101, 1'b0, 64'hAA};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", bus.out_valid, 1'b1);
      check("t3_hold_flit", bus.out_flit, lit_flit(64'h35));
      check("t3_hold_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) cnt++;
    end
    check("t3_count", cnt, NUM_DEST);
    check("t3_ready_back", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Overwrite rule and ignored flits: A=1, A=3, junk, B=2 -> OR = 3.
    bus.op_sel = 2'b01;
    send(1'b0, 64'h1);
    send(1'b0, 64'h3);
    send(1'b1, 64'h5, 1'b1, 1'b0);
    send(1'b1, 64'h7, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_no_out", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    send(1'b1, 64'h2);
    @(negedge clk);
    check("t4_or", bus.out_flit, lit_flit(64'h3));
    @(posedge clk); #1;
    wait_idle("t4_idle");

    // Reset while the second flit (idx=1) is pending.
    bus.op_sel = 2'b00;
    send(1'b0, 64'hF0);
    send(1'b1, 64'h3C);
    @(negedge clk);
    check("t5_flit0", bus.out_flit, lit_flit(64'h30));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.out_valid, 1'b0);
    check("t5_rst_busy", bus.busy, 1'b0);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 64'h55);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_out", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
`else
    // Constant A: B=0xE AND 6 -> 0x6; a vc0 flit does nothing.
    bus.op_sel = 2'b00;
    send(1'b1, 64'hE);
    @(negedge clk);
    check("t6_const", bus.out_flit, lit_flit(64'h6));
    @(posedge clk); #1;
    wait_idle("t6_idle");
    send(1'b0, 64'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_vc0_ignored", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      flit_t f;
      f.valid = ($urandom_range(0, 3) != 0);
      f.head  = ($urandom_range(0, 3) != 0);
      f.dest  = 4'($urandom);
      f.vc    = 1'($urandom);
      f.data  = {$urandom, $urandom};
      bus.in_flit   = f;
      bus.op_sel    = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
    wait_idle("rand_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/noc_logic_pe.md
Name: noc_logic_pe

Overview:
- Parametrised bitwise-logic processing element on a mesh NoC router local port.
- Collects two operand flits, distinguished by the VC bit, and computes AND/OR/XOR/NAND of them.
- Fans the result out as one flit per destination to a parameter-defined list, with valid/ready backpressure on output and ready on input.
- Successor to the single-op, single-destination, no-backpressure AND node.

Parameters:
- DATA_W, 64, payload width.
- DEST_W, 4, router address width.
- NUM_DEST, 2, result flits emitted per operation (1..16).
- DEST_LIST, {4'b0101,4'b0101}, packed NUM_DEST*DEST_W destination table; entry 0 in LSBs.
- VC_LIST, 2'b00, packed NUM_DEST outgoing VC bits; entry 0 in LSB.
- CONST_A, 64'd6, operand A value when the optional feature is enabled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_flit  in  FLIT_W  incoming flit. FLIT_W = DATA_W+DEST_W+3 = 71. Fields: [MSB] valid, [MSB-1] head, dest, vc (bit DATA_W), data.
- in_ready  out  1  PE can accept a flit this cycle.
- op_sel  in  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled when the pair completes.
- out_flit  out  FLIT_W  result flit.
- out_valid  out  1  out_flit is valid.
- out_ready  in  1  downstream accepts out_flit.
- busy  out  1  high while in SEND.

Behaviour:
- Reset (async): state=COLLECT, flag_a=flag_b=0, out_valid=0, out_flit=0, dest index idx=0, result=0, busy=0.
- Accept condition: valid & head & in_ready. Flits failing this are ignored with no state change.
- COLLECT: in_ready=1.
  - Accepted flit with vc=0 loads operand A and sets flag_a.
  - Accepted flit with vc=1 loads operand B and sets flag_b.
  - A repeat flit to an already-filled slot overwrites the data; the flag stays set.
- Pair completion (both flags set after the accepting edge):
  - On that same edge: result <= op(A,B) per op_sel, full DATA_W; idx <= 0; state <= SEND.
  - out_flit <= {1,1,DEST_LIST[0],VC_LIST[0],result}; out_valid <= 1.
  - Latency: out_valid rises the cycle after the completing flit is accepted.
- SEND: in_ready=0, busy=1. out_flit and out_valid are held stable while out_valid & !out_ready.
- On out_valid & out_ready:
  - If idx < NUM_DEST-1: idx++, out_flit reloads with the next DEST_LIST/VC_LIST entry, out_valid stays 1. This allows back-to-back flits, one per cycle.
  - If idx == NUM_DEST-1: out_valid <= 0, flags cleared, idx <= 0, state <= COLLECT. in_ready is high the next cycle.
- A flit presented during SEND is not accepted (in_ready=0). The sender must hold it.
- op_sel changes during SEND have no effect on the result in flight.
- Reset asserted mid-SEND aborts the remaining flits immediately; operands are discarded.
- NUM_DEST=1: a single flit, then return to COLLECT.
- idx width: $clog2(NUM_DEST), minimum 1.

Optional Feature:
- Macro NOC_LOGIC_PE_CONST_A_EN.
- Defined:
  - Operand A is fixed to CONST_A and flag_a is treated as always set.
  - vc=0 flits are ignored, not accepted.
  - A pair completes on any accepted vc=1 flit.
- Undefined: two-operand collection as above.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W / field-position localparams.
  - flit_t packed struct {valid, head, dest, vc, data}.
  - logic_op_e enum (AND, OR, XOR, NAND).
  - State enum {COLLECT, SEND}.
- One sub-module: noc_flit_fanout. It holds idx, the DEST_LIST/VC_LIST lookup and the out_valid/out_ready sequencing; the top keeps operand collection and the ALU.

Test Plan:
- A=6 (vc0), then B=0xF (vc1), op=AND, out_ready=1 -> two flits, each {1,1,0101,0,0x6}, on consecutive cycles; first appears 1 cycle after B is accepted.
- B first, then A, op=XOR, A=0xFF, B=0x0F -> result 0xF0; arrival order is irrelevant.
- out_ready held low 5 cycles after out_valid -> out_flit stable and in_ready=0 throughout; after release, NUM_DEST flits are sent, then in_ready returns to 1.
- A=1, A=3, then B=2, op=OR -> result 0x3 (overwrite rule); a flit with head=0 or valid=0 mid-sequence is ignored.
- Reset asserted while idx=1 of NUM_DEST=2 -> out_valid=0 the same cycle; a following single B does not produce output.
- With NOC_LOGIC_PE_CONST_A_EN, B=0xE, op=AND -> result 0x6; a vc0 flit produces no output.
